// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and default width shared by the divider files
package seq_divider_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus between ALU control and divider
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring-division iteration
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  // rem < dvs <= 2^(WIDTH-1), so shifted fits and trial's MSB is a true sign bit
  always_comb begin
    shifted = {rem, din};
    trial   = shifted - {1'b0, dvs};
    q       = ~trial[WIDTH];
    rem_nx  = q ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per clock, fixed WIDTH+1 latency
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, a_q, a_d;
  logic [WIDTH-1:0] quot_q, quot_d, remd_q, remd_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ov_q, ov_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem_q),
    .din    (dvd_q[WIDTH-1]),
    .dvs    (dvs_q),
    .rem_nx (step_rem),
    .q      (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    busy_d  = state_q == CALC;
    done_d  = state_q == FIX;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CALC;
        cnt_d   = '0;
        rem_d   = '0;
        dvd_d   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_d   = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
        a_d     = bus.dividend;
        sa_d    = bus.dividend[WIDTH-1];
        sb_d    = bus.divisor[WIDTH-1];
        dz_d    = bus.divisor == '0;
        ov_d    = bus.dividend == MIN_NEG && bus.divisor == '1;
      end
      CALC: begin
        rem_d   = step_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], step_bit};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        quot_d  = dz_q ? '1 : ov_q ? MIN_NEG : (sa_q ^ sb_q) ? -dvd_q : dvd_q;
        remd_d  = dz_q ? a_q : ov_q ? '0 : sa_q ? -rem_q : rem_q;
        dbz_d   = dz_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dbz_q;
endmodule
